// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: per-wheel duty/direction sequencer in front of pwm_gen/dir_sel.
// Slews duty toward the software target one STEP per ramp tick, ramps to zero
// and waits out a dead time before any direction reversal, and latches an
// emergency stop until software drops the enable.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | bridge disabled, duty 0, waiting for tgt_en
// S_RUN       | enabled, duty slewing toward tgt_duty in the current direction
// S_RAMP_DOWN | direction change requested, duty slewing to 0
// S_DEAD      | duty 0, bridge enabled, dead time before the direction flips
// S_FAULT     | emergency stop latched, duty 0, bridge disabled

module motor_ramp_ctrl #(
    parameter int RAMP_DIV    = 1000,
    parameter int STEP        = 1,
    parameter int DEAD_CYCLES = 100
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic [7:0] tgt_duty,
    input  logic       tgt_dir,
    input  logic       tgt_en,
    input  logic       estop,
    output logic [7:0] duty_out,
    output logic       dir_out,
    output logic       en_out,
    output logic       busy,
    output logic       fault
);

    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_RAMP_DOWN,
        S_DEAD,
        S_FAULT
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [DW-1:0] dead_cnt, dead_nx;
    logic [7:0]    duty_nx;
    logic          dir_nx;
    logic          en_nx;
    logic [8:0]    sum9;
    logic [8:0]    dif9;
    logic [7:0]    up_val;
    logic [7:0]    dn_val;
    logic [7:0]    dn_zero;
    logic [7:0]    approach;

    // Reset asserts immediately, releases two PCLK edges later so all flops leave reset together.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Free-running ramp tick divider, independent of the FSM.
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Saturating step arithmetic, done in 9 bits so neither direction can wrap.
    always_comb begin
        sum9    = {1'b0, duty_out} + STEP9;
        dif9    = {1'b0, duty_out} - STEP9;
        up_val  = (sum9 > {1'b0, tgt_duty}) ? tgt_duty : sum9[7:0];
        dn_val  = (dif9[8] || (dif9[7:0] < tgt_duty)) ? tgt_duty : dif9[7:0];
        dn_zero = dif9[8] ? 8'd0 : dif9[7:0];
        if (duty_out < tgt_duty)      approach = up_val;
        else if (duty_out > tgt_duty) approach = dn_val;
        else                          approach = duty_out;
    end

    // Next state and next register values; estop beats tgt_en beats the per-state rules.
    always_comb begin
        state_nx = state;
        duty_nx  = duty_out;
        dir_nx   = dir_out;
        en_nx    = en_out;
        dead_nx  = dead_cnt;

        if (estop) begin
            state_nx = S_FAULT;
            duty_nx  = 8'd0;
            en_nx    = 1'b0;
        end else if (state == S_FAULT) begin
            duty_nx = 8'd0;
            en_nx   = 1'b0;
            if (!tgt_en) state_nx = S_IDLE;
        end else if (!tgt_en) begin
            state_nx = S_IDLE;
            duty_nx  = 8'd0;
            en_nx    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_RUN;
                    dir_nx   = tgt_dir;
                    duty_nx  = 8'd0;
                    en_nx    = 1'b1;
                end
                S_RUN: begin
                    if (tgt_dir != dir_out) begin
                        if (duty_out == 8'd0) begin
                            state_nx = S_DEAD;
                            dead_nx  = DEAD_LOAD;
                        end else begin
                            state_nx = S_RAMP_DOWN;
                        end
                    end else if (tick) begin
                        duty_nx = approach;
                    end
                end
                S_RAMP_DOWN: begin
                    if (tgt_dir == dir_out) begin
                        state_nx = S_RUN;
                    end else if (duty_out == 8'd0) begin
                        state_nx = S_DEAD;
                        dead_nx  = DEAD_LOAD;
                    end else if (tick) begin
                        duty_nx = dn_zero;
                    end
                end
                S_DEAD: begin
                    duty_nx = 8'd0;
                    en_nx   = 1'b1;
                    if (dead_cnt == '0) begin
                        state_nx = S_RUN;
                        dir_nx   = tgt_dir;
                    end else begin
                        dead_nx = dead_cnt - DW'(1);
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    duty_nx  = 8'd0;
                    en_nx    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            duty_out <= 8'd0;
            dir_out  <= 1'b0;
            en_out   <= 1'b0;
            fault    <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nx;
            duty_out <= duty_nx;
            dir_out  <= dir_nx;
            en_out   <= en_nx;
            fault    <= (state_nx == S_FAULT);
            dead_cnt <= dead_nx;
        end
    end

    assign busy = (state == S_RAMP_DOWN) || (state == S_DEAD) ||
                  ((state == S_RUN) && ((duty_out != tgt_duty) || (dir_out != tgt_dir)));

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with RAMP_DIV=4, STEP=16, DEAD_CYCLES=8,
// plus a STEP=255 instance for the single-tick full-scale case.
module tb_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [7:0] tgt_duty;
    logic       tgt_dir, tgt_en, estop;
    logic [7:0] duty_out;
    logic       dir_out, en_out, busy, fault;

    logic [7:0] tgt_duty_b;
    logic       tgt_en_b;
    logic       zero_b;
    logic [7:0] duty_b;
    logic       dir_b, en_b, busy_b, fault_b;

    int   checks   = 0;
    int   failures = 0;
    logic en_lost, dir_moved, dir_ref;

    always #5 clk = ~clk;

    motor_ramp_ctrl #(.RAMP_DIV(4), .STEP(16), .DEAD_CYCLES(8)) u_dut (
        .PCLK(clk), .PRESERN(rst_b), .tgt_duty(tgt_duty), .tgt_dir(tgt_dir),
        .tgt_en(tgt_en), .estop(estop), .duty_out(duty_out), .dir_out(dir_out),
        .en_out(en_out), .busy(busy), .fault(fault)
    );

    motor_ramp_ctrl #(.RAMP_DIV(4), .STEP(255), .DEAD_CYCLES(8)) u_fast (
        .PCLK(clk), .PRESERN(rst_b), .tgt_duty(tgt_duty_b), .tgt_dir(zero_b),
        .tgt_en(tgt_en_b), .estop(zero_b), .duty_out(duty_b), .dir_out(dir_b),
        .en_out(en_b), .busy(busy_b), .fault(fault_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for duty_out to change; cyc = -1 if it never does within 40 cycles.
    task automatic wait_change(output int cyc, output logic [7:0] val);
        logic [7:0] prev;
        prev = duty_out;
        cyc  = -1;
        val  = duty_out;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (en_out !== 1'b1) en_lost = 1'b1;
            if (dir_out !== dir_ref) dir_moved = 1'b1;
            if (duty_out !== prev) begin
                cyc = i;
                val = duty_out;
                break;
            end
        end
    endtask

    task automatic wait_duty(input logic [7:0] target, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (duty_out === target) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        checks++; if (duty_out !== 8'd0) begin failures++; $display("FAIL reset_duty got=%0d want=0", duty_out); end
        checks++; if (dir_out !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b want=0", dir_out); end
        checks++; if (en_out !== 1'b0) begin failures++; $display("FAIL reset_en got=%b want=0", en_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", fault); end
        checks++; if ({duty_b, dir_b, en_b, busy_b, fault_b} !== 12'd0) begin
            failures++; $display("FAIL reset_fast got=%h want=0", {duty_b, dir_b, en_b, busy_b, fault_b});
        end
    endtask

    task automatic test_ramp_up;
        int         seq[7] = '{16, 32, 48, 64, 80, 96, 100};
        int         c;
        logic [7:0] v;
        tgt_duty = 8'd100; tgt_dir = 1'b0; tgt_en = 1'b1;
        step(1);
        checks++; if (en_out !== 1'b1) begin failures++; $display("FAIL up_en got=%b want=1", en_out); end
        checks++; if (duty_out !== 8'd0) begin failures++; $display("FAIL up_start_duty got=%0d want=0", duty_out); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up_busy got=%b want=1", busy); end
        dir_ref = 1'b0; en_lost = 1'b0; dir_moved = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wait_change(c, v);
            checks++; if (v !== 8'(seq[i])) begin failures++; $display("FAIL up_step%0d got=%0d want=%0d", i, v, seq[i]); end
            checks++;
            if ((i == 0 && (c < 1 || c > 4)) || (i > 0 && c != 4)) begin
                failures++; $display("FAIL up_spacing%0d got=%0d want=%s", i, c, (i == 0) ? "1..4" : "4");
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_busy_done got=%b want=0", busy); end
        checks++; if (en_lost || dir_moved) begin failures++; $display("FAIL up_hold got=en_lost%b dir_moved%b want=00", en_lost, dir_moved); end
    endtask

    task automatic test_reversal;
        int         dn[7] = '{84, 68, 52, 36, 20, 4, 0};
        int         up[7] = '{16, 32, 48, 64, 80, 96, 100};
        int         c;
        logic [7:0] v;
        logic       dead_bad;
        dir_ref = 1'b0; en_lost = 1'b0; dir_moved = 1'b0;
        tgt_dir = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_change(c, v);
            checks++; if (v !== 8'(dn[i])) begin failures++; $display("FAIL rev_down%0d got=%0d want=%0d", i, v, dn[i]); end
            checks++;
            if ((i == 0 && (c < 1 || c > 5)) || (i > 0 && c != 4)) begin
                failures++; $display("FAIL rev_down_spacing%0d got=%0d", i, c);
            end
        end
        checks++; if (en_lost || dir_moved) begin failures++; $display("FAIL rev_down_hold got=en_lost%b dir_moved%b want=00", en_lost, dir_moved); end
        dead_bad = 1'b0;
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (en_out !== 1'b1 || duty_out !== 8'd0) dead_bad = 1'b1;
            if (dir_out === 1'b1) begin
                c = i;
                break;
            end
        end
        checks++; if (c != 9) begin failures++; $display("FAIL rev_dead_len got=%0d want=9", c); end
        checks++; if (dead_bad) begin failures++; $display("FAIL rev_dead_outputs got=bad want=duty0_en1"); end
        dir_ref = 1'b1; en_lost = 1'b0; dir_moved = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wait_change(c, v);
            checks++; if (v !== 8'(up[i])) begin failures++; $display("FAIL rev_up%0d got=%0d want=%0d", i, v, up[i]); end
        end
        checks++; if (en_lost || dir_moved) begin failures++; $display("FAIL rev_up_hold got=en_lost%b dir_moved%b want=00", en_lost, dir_moved); end
    endtask

    task automatic test_abort_reversal;
        int         seq[6] = '{84, 68, 52, 68, 84, 100};
        int         c;
        logic [7:0] v;
        dir_ref = 1'b1; en_lost = 1'b0; dir_moved = 1'b0;
        tgt_dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_change(c, v);
            checks++; if (v !== 8'(seq[i])) begin failures++; $display("FAIL abort_step%0d got=%0d want=%0d", i, v, seq[i]); end
            if (i == 2) tgt_dir = 1'b1;
            if (i >= 3) begin
                checks++; if (c != 4) begin failures++; $display("FAIL abort_spacing%0d got=%0d want=4", i, c); end
            end
        end
        checks++; if (en_lost || dir_moved) begin failures++; $display("FAIL abort_hold got=en_lost%b dir_moved%b want=00", en_lost, dir_moved); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    endtask

    task automatic test_estop;
        int         seq[3] = '{84, 68, 64};
        int         c;
        logic [7:0] v;
        dir_ref = 1'b1;
        tgt_duty = 8'd64;
        for (int i = 0; i < 3; i++) begin
            wait_change(c, v);
            checks++; if (v !== 8'(seq[i])) begin failures++; $display("FAIL estop_pre%0d got=%0d want=%0d", i, v, seq[i]); end
        end
        estop = 1'b1;
        step(1);
        estop = 1'b0;
        checks++; if ({duty_out, en_out, fault} !== {8'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL estop_hit got=duty%0d en%b fault%b want=duty0 en0 fault1", duty_out, en_out, fault);
        end
        step(3);
        checks++; if ({duty_out, en_out, fault} !== {8'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL estop_latched got=duty%0d en%b fault%b want=duty0 en0 fault1", duty_out, en_out, fault);
        end
        tgt_en = 1'b0;
        step(1);
        checks++; if ({en_out, fault} !== 2'b00) begin failures++; $display("FAIL estop_clear got=en%b fault%b want=en0 fault0", en_out, fault); end
        tgt_en = 1'b1;
        step(1);
        checks++; if ({duty_out, en_out, dir_out} !== {8'd0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL estop_rearm got=duty%0d en%b dir%b want=duty0 en1 dir1", duty_out, en_out, dir_out);
        end
        wait_change(c, v);
        checks++; if (v !== 8'd16 || c < 1 || c > 4) begin failures++; $display("FAIL estop_first_step got=%0d@%0d want=16@1..4", v, c); end
    endtask

    task automatic test_saturation;
        int         c;
        logic [7:0] v;
        bit         ok;
        tgt_duty = 8'd240;
        wait_duty(8'd240, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sat_reach240 got=%0d want=240", duty_out); end
        tgt_duty = 8'd250;
        wait_change(c, v);
        checks++; if (v !== 8'd250) begin failures++; $display("FAIL sat_up250 got=%0d want=250", v); end
        tgt_duty = 8'd20;
        wait_duty(8'd20, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sat_reach20 got=%0d want=20", duty_out); end
        tgt_duty = 8'd5;
        wait_change(c, v);
        checks++; if (v !== 8'd5) begin failures++; $display("FAIL sat_down5 got=%0d want=5", v); end
        tgt_en = 1'b0;
        step(1);
        checks++; if ({duty_out, en_out, busy} !== {8'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL sat_disable got=duty%0d en%b busy%b want=duty0 en0 busy0", duty_out, en_out, busy);
        end

        tgt_duty_b = 8'd255; tgt_en_b = 1'b1;
        step(1);
        checks++; if (en_b !== 1'b1) begin failures++; $display("FAIL fast_en got=%b want=1", en_b); end
        c = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (duty_b !== 8'd0) begin c = i; break; end
        end
        checks++; if (duty_b !== 8'd255 || c < 1 || c > 4) begin failures++; $display("FAIL fast_up got=%0d@%0d want=255@1..4", duty_b, c); end
        tgt_duty_b = 8'd0;
        c = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (duty_b !== 8'd255) begin c = i; break; end
        end
        checks++; if (duty_b !== 8'd0 || c < 1 || c > 4) begin failures++; $display("FAIL fast_down got=%0d@%0d want=0@1..4", duty_b, c); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL fast_busy got=%b want=0", busy_b); end
    endtask

    task automatic test_reset_in_dead;
        bit ok;
        tgt_duty = 8'd32; tgt_dir = 1'b1; tgt_en = 1'b1;
        step(1);
        wait_duty(8'd32, 20, ok);
        checks++; if (!ok || dir_out !== 1'b1) begin failures++; $display("FAIL rst_setup got=duty%0d dir%b want=duty32 dir1", duty_out, dir_out); end
        tgt_dir = 1'b0;
        wait_duty(8'd0, 30, ok);
        step(3);
        checks++; if (!ok || {en_out, dir_out, busy} !== 3'b111) begin
            failures++; $display("FAIL rst_in_dead got=en%b dir%b busy%b want=111", en_out, dir_out, busy);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++; if ({duty_out, dir_out, en_out, busy, fault} !== 12'd0) begin
            failures++; $display("FAIL rst_async got=duty%0d dir%b en%b busy%b fault%b want=0", duty_out, dir_out, en_out, busy, fault);
        end
        tgt_en = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_b = 1'b1;
        step(4);
        checks++; if ({duty_out, dir_out, en_out, fault} !== 11'd0) begin
            failures++; $display("FAIL rst_release got=duty%0d dir%b en%b fault%b want=0", duty_out, dir_out, en_out, fault);
        end
        tgt_en = 1'b1; tgt_dir = 1'b1;
        step(1);
        checks++; if ({en_out, dir_out} !== 2'b11) begin failures++; $display("FAIL rst_reenable got=en%b dir%b want=11", en_out, dir_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b = 1'b0;
        tgt_duty = 8'd0; tgt_dir = 1'b0; tgt_en = 1'b0; estop = 1'b0;
        tgt_duty_b = 8'd0; tgt_en_b = 1'b0; zero_b = 1'b0;
        dir_ref = 1'b0; en_lost = 1'b0; dir_moved = 1'b0;
        step(3);
        rst_b = 1'b1;
        step(4);
        test_reset;
        test_ramp_up;
        test_reversal;
        test_abort_reversal;
        test_estop;
        test_saturation;
        test_reset_in_dead;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
